wt_mem_responder: RTL and testbench

- Memory-side responder for the write-through data cache request/response interface.
- Accepts tagged load/store requests (transaction ID of MemTidWidth bits) and services them from an internal single-port word SRAM covering the cached region.
- Returns tagged responses in request order.
- Used as the far end of the cache miss/write path in FPGA and simulation builds. Requests outside the window get an error response.

---
 rtl/wt_mem_responder.sv | 145 ++++++++++++++
 tb/tb_wt_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through cache request/response interface.
// Serves tagged loads/stores from a word SRAM and returns in-order tagged responses.
module wt_mem_responder #(
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          TidWidth  = 2,
  parameter logic [AddrWidth-1:0] BaseAddr  = 32'h8000_0000,
  parameter int unsigned          NumWords  = 1024,
  parameter int unsigned          RespDepth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  input  logic [TidWidth-1:0]    req_tid_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic [TidWidth-1:0]    rsp_tid_o,
  output logic                   rsp_we_o,
  output logic                   rsp_err_o
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned OffLsb  = $clog2(BeWidth);
  localparam int unsigned IdxW    = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned PtrW    = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW    = $clog2(RespDepth + 1);
  localparam logic [AddrWidth:0] WinBytes = (AddrWidth+1)'(NumWords * BeWidth);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RespDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [AddrWidth-1:0] off;
  logic                 in_range;
  logic [IdxW-1:0]      idx;
  logic                 accept;
  logic                 sram_we;
  logic                 sram_re;

  always_comb begin
    off      = req_addr_i - BaseAddr;
    in_range = (req_addr_i >= BaseAddr) && ({1'b0, off} < WinBytes) &&
               (off[OffLsb-1:0] == '0);
    idx      = off[OffLsb +: IdxW];
    accept   = req_valid_i && req_ready_o;
    sram_we  = accept && req_we_i && in_range;
    sram_re  = accept && !req_we_i && in_range;
  end

  // ---- p0: SRAM access at the acceptance edge ----
  logic [DataWidth-1:0] mem_q [NumWords];

  always_ff @(posedge clk_i) begin
    if (sram_we) begin
      for (int b = 0; b < BeWidth; b++) begin
        if (req_be_i[b]) mem_q[idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
      end
    end
  end

  logic [DataWidth-1:0] rdata_p0_q;
  logic [TidWidth-1:0]  tid_p0_q, tid_p0_d;
  logic                 we_p0_q, we_p0_d;
  logic                 err_p0_q, err_p0_d;
  logic                 vld_p0_q, vld_p0_d;

  always_comb begin
    vld_p0_d = accept;
    tid_p0_d = accept ? req_tid_i : tid_p0_q;
    we_p0_d  = accept ? req_we_i : we_p0_q;
    err_p0_d = accept ? !in_range : err_p0_q;
  end

  // Stores and rejected requests return zero data.
  always_ff @(posedge clk_i) begin
    if (accept) rdata_p0_q <= sram_re ? mem_q[idx] : '0;
    tid_p0_q <= tid_p0_d;
    we_p0_q  <= we_p0_d;
    err_p0_q <= err_p0_d;
  end

  // ---- p1: stage result enters the response FIFO ----
  logic [DataWidth-1:0] fifo_rdata_q [RespDepth];
  logic [TidWidth-1:0]  fifo_tid_q   [RespDepth];
  logic                 fifo_we_q    [RespDepth];
  logic                 fifo_err_q   [RespDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW:0]        outstanding;
  logic                 push;
  logic                 pop;

  always_comb begin
    push     = vld_p0_q;
    pop      = (cnt_q != '0) && rsp_ready_i;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_p0_q <= vld_p0_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rdata_q[wr_ptr_q] <= rdata_p0_q;
      fifo_tid_q[wr_ptr_q]   <= tid_p0_q;
      fifo_we_q[wr_ptr_q]    <= we_p0_q;
      fifo_err_q[wr_ptr_q]   <= err_p0_q;
    end
  end

  // Credits come from registered state only, so a freed slot is seen one cycle late.
  always_comb begin
    outstanding = {1'b0, cnt_q} + {{CntW{1'b0}}, vld_p0_q};
    req_ready_o = outstanding < (CntW+1)'(RespDepth);
    rsp_valid_o = (cnt_q != '0);
    rsp_rdata_o = rsp_valid_o ? fifo_rdata_q[rd_ptr_q] : '0;
    rsp_tid_o   = rsp_valid_o ? fifo_tid_q[rd_ptr_q] : '0;
    rsp_we_o    = rsp_valid_o ? fifo_we_q[rd_ptr_q] : 1'b0;
    rsp_err_o   = rsp_valid_o ? fifo_err_q[rd_ptr_q] : 1'b0;
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (cnt_q == CntW'(RespDepth))));

endmodule

// File: tb/tb_wt_mem_responder.sv
// Directed bench for wt_mem_responder with a response scoreboard and byte-enable memory model.
module tb_wt_mem_responder;

  localparam int          NW   = 1024;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic [1:0]  req_tid;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_tid;
  logic        rsp_we, rsp_err;

  typedef struct packed {
    logic [63:0] rdata;
    logic [1:0]  tid;
    logic        we;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        last_pop;
  logic [63:0] model [NW];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          acc_cnt = 0;
  logic        last_acc = 1'b0;

  always #5 clk = ~clk;

  wt_mem_responder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .req_tid_i   (req_tid),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_tid_o   (rsp_tid),
    .rsp_we_o    (rsp_we),
    .rsp_err_o   (rsp_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept();
    logic [31:0] off;
    logic        ok;
    int          idx;
    rsp_t        e;
    off     = req_addr - BASE;
    ok      = (req_addr >= BASE) && (off < 32'(NW * 8)) && (off[2:0] == 3'b000);
    idx     = int'(off >> 3);
    e.tid   = req_tid;
    e.we    = req_we;
    e.err   = !ok;
    e.rdata = '0;
    if (ok && req_we) begin
      for (int b = 0; b < 8; b++) begin
        if (req_be[b]) model[idx][b*8 +: 8] = req_wdata[b*8 +: 8];
      end
    end
    if (ok && !req_we) e.rdata = model[idx];
    exp_q.push_back(e);
  endtask

  // One clock: decide handshakes on pre-edge values, then score any popped response.
  task automatic tick();
    logic acc, pop;
    rsp_t got, e;
    acc = req_valid && req_ready;
    pop = rsp_valid && rsp_ready;
    got = {rsp_rdata, rsp_tid, rsp_we, rsp_err};
    if (acc) model_accept();
    @(posedge clk);
    #1;
    last_acc = acc;
    if (acc) acc_cnt++;
    if (pop) begin
      check("rsp_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_scoreboard", 128'(got), 128'(e));
      end
      last_pop = got;
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] be, input logic [1:0] tid);
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    req_tid   = tid;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    check("accept_in_time", 128'(last_acc), 128'(1));
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int acc_before;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    req_tid   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    check("reset_req_ready", 128'(req_ready), 128'(1));
    check("reset_rsp_fields", 128'({rsp_rdata, rsp_tid, rsp_we, rsp_err}), 128'(0));

    // Store then load of the same word on consecutive edges
    rsp_ready = 1'b1;
    issue(1'b1, 32'h8000_0008, 64'h1122334455667788, 8'hFF, 2'd1);
    check("store_lat_edge0", 128'(rsp_valid), 128'(0));
    issue(1'b0, 32'h8000_0008, 64'h0, 8'h00, 2'd2);
    check("store_lat_edge1", 128'(rsp_valid), 128'(1));
    check("store_rsp_fields", 128'({rsp_tid, rsp_we, rsp_err, rsp_rdata}),
          128'({2'd1, 1'b1, 1'b0, 64'h0}));
    drain();
    check("raw_load_data", 128'({last_pop.tid, last_pop.rdata}),
          128'({2'd2, 64'h1122334455667788}));
    issue(1'b1, 32'h8000_0008, 64'h00000000000000AA, 8'h01, 2'd3);
    issue(1'b0, 32'h8000_0008, 64'h0, 8'h00, 2'd0);
    drain();
    check("byte_enable_merge", 128'(last_pop.rdata), 128'(64'h11223344556677AA));

    // Backpressure: only two requests may be outstanding
    rsp_ready = 1'b0;
    issue(1'b0, 32'h8000_0008, 64'h0, 8'h00, 2'd0);
    issue(1'b0, 32'h8000_0008, 64'h0, 8'h00, 2'd1);
    check("credit_ready_low", 128'(req_ready), 128'(0));
    acc_before = acc_cnt;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h8000_0008;
    req_tid    = 2'd2;
    repeat (3) tick();
    check("credit_no_accept", 128'(acc_cnt - acc_before), 128'(0));
    check("credit_ready_held", 128'(req_ready), 128'(0));
    check("credit_head_tid", 128'({rsp_valid, rsp_tid}), 128'({1'b1, 2'd0}));
    rsp_ready = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        tick();
        n++;
      end while (!last_acc && n < 20);
      check("credit_third_accept", 128'(last_acc), 128'(1));
    end
    req_valid = 1'b0;
    drain();
    check("credit_last_tid", 128'(last_pop.tid), 128'(2'd2));

    // Window boundaries and misalignment
    issue(1'b1, 32'h8000_0000, 64'hDEADBEEFCAFEF00D, 8'hFF, 2'd0);
    issue(1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, 2'd1);
    issue(1'b1, 32'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'd2);
    issue(1'b0, 32'h8000_0004, 64'h0, 8'h00, 2'd3);
    drain();
    check("misaligned_err", 128'({last_pop.err, last_pop.rdata}), 128'({1'b1, 64'h0}));
    issue(1'b1, 32'h8000_1FF8, 64'h0102030405060708, 8'hFF, 2'd0);
    issue(1'b0, 32'h8000_1FF8, 64'h0, 8'h00, 2'd1);
    drain();
    check("last_word_load", 128'({last_pop.err, last_pop.rdata}),
          128'({1'b0, 64'h0102030405060708}));
    issue(1'b0, 32'h8000_0000, 64'h0, 8'h00, 2'd2);
    drain();
    check("err_store_no_effect", 128'(last_pop.rdata), 128'(64'hDEADBEEFCAFEF00D));

    // Alternating store/load stream to one word
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        issue(1'b1, 32'h8000_0018, {32'(i) ^ 32'hA5A5_0000, 32'(i * 7)}, 8'hFF, 2'(i));
      else
        issue(1'b0, 32'h8000_0018, 64'h0, 8'h00, 2'(i));
    end
    drain();
    check("stream_last_load", 128'(last_pop.rdata),
          128'({32'(14) ^ 32'hA5A5_0000, 32'(14 * 7)}));

    // Asynchronous reset with responses queued
    rsp_ready = 1'b0;
    issue(1'b0, 32'h8000_0008, 64'h0, 8'h00, 2'd1);
    issue(1'b0, 32'h8000_0018, 64'h0, 8'h00, 2'd2);
    tick();
    check("queued_before_reset", 128'(rsp_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("async_reset_valid", 128'(rsp_valid), 128'(0));
    check("async_reset_fields", 128'({rsp_rdata, rsp_tid, rsp_we, rsp_err}), 128'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_reset_ready", 128'(req_ready), 128'(1));
    rsp_ready = 1'b1;
    repeat (3) tick();
    check("no_stale_rsp", 128'(rsp_valid), 128'(0));
    issue(1'b0, 32'h8000_0008, 64'h0, 8'h00, 2'd3);
    drain();
    check("mem_survives_reset", 128'({last_pop.tid, last_pop.rdata}),
          128'({2'd3, 64'h11223344556677AA}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
